// File: rtl/m68k_uart_periph_pkg.sv
// Shared definitions for the j68 SOC UART target: register offsets, STATUS
// bit positions, the UART base address used by the SOC decoder, the common
// serial FSM state type and the divisor clamp helper.
package m68k_uart_periph_pkg;

  // Base of the 16-byte UART window, decoded into sel by the SOC top.
  localparam logic [31:0] UART_BASE_ADDR = 32'hFF00_0010;

  // Register index on address[3:1].
  localparam logic [2:0] UART_REG_DATA   = 3'd0;
  localparam logic [2:0] UART_REG_STATUS = 3'd1;
  localparam logic [2:0] UART_REG_DIV    = 3'd2;

  // STATUS bit positions.
  localparam int STAT_RX_VALID  = 0;
  localparam int STAT_TX_FULL   = 1;
  localparam int STAT_TX_BUSY   = 2;
  localparam int STAT_RX_OVR    = 3;
  localparam int STAT_FRAME_ERR = 4;
  localparam int STAT_TX_OVR    = 5;

  // Shared by the TX and RX sequencers.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Complete sequencer state kept in one struct so a checker can bind to it.
  // div is the bit period latched at the last bit boundary.
  typedef struct packed {
    uart_state_e state;
    logic [2:0]  bit_cnt;
    logic [15:0] baud_cnt;
    logic [15:0] div;
  } uart_fsm_t;

  localparam uart_fsm_t UART_FSM_RESET = '{
    state:    ST_IDLE,
    bit_cnt:  3'd0,
    baud_cnt: 16'd0,
    div:      16'd2
  };

  // A bit period shorter than 2 clocks breaks the RX mid-bit sampler.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

endpackage

// File: rtl/m68k_uart_rx.sv
// 8N1 receiver: 2-FF synchroniser, falling-edge start detect, mid-start
// glitch reject, mid-bit data sampling, stop-bit check.
// rx_strobe pulses for one clock with rx_byte valid; rx_frame_err pulses for
// one clock when the stop bit is sampled low (the byte is discarded).
module m68k_uart_rx
  import m68k_uart_periph_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] div,
  input  logic        uart_rx,
  output logic [7:0]  rx_byte,
  output logic        rx_strobe,
  output logic        rx_frame_err
);

  logic        sync1, sync2, rx_prev;
  uart_fsm_t   rx_q, rx_d;
  logic [7:0]  shift_q, shift_d;
  logic        strobe_d, ferr_d;
  logic [15:0] half_div;
  logic        bit_end;

  assign half_div = {1'b0, rx_q.div[15:1]};
  assign bit_end  = (rx_q.baud_cnt == rx_q.div - 16'd1);

  // Synchronise the asynchronous line and keep one delayed copy for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= uart_rx;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  // Sequencer state, shift register and output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q         <= UART_FSM_RESET;
      shift_q      <= 8'h00;
      rx_strobe    <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_q         <= rx_d;
      shift_q      <= shift_d;
      rx_strobe    <= strobe_d;
      rx_frame_err <= ferr_d;
    end
  end

  // Next state: re-check start at half a bit, then sample every full bit.
  always_comb begin
    rx_d          = rx_q;
    shift_d       = shift_q;
    strobe_d      = 1'b0;
    ferr_d        = 1'b0;
    rx_d.baud_cnt = rx_q.baud_cnt + 16'd1;
    case (rx_q.state)
      ST_IDLE: begin
        rx_d.baud_cnt = 16'd0;
        rx_d.bit_cnt  = 3'd0;
        rx_d.div      = div;
        if (rx_prev && !sync2) rx_d.state = ST_START;
      end
      ST_START: begin
        if (rx_q.baud_cnt == half_div - 16'd1) begin
          rx_d.baud_cnt = 16'd0;
          rx_d.div      = div;
          // Line back high at mid-start: treat as a glitch.
          rx_d.state    = sync2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          rx_d.baud_cnt = 16'd0;
          rx_d.div      = div;
          shift_d       = {sync2, shift_q[7:1]};
          if (rx_q.bit_cnt == 3'd7) rx_d.state = ST_STOP;
          else                      rx_d.bit_cnt = rx_q.bit_cnt + 3'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          rx_d.baud_cnt = 16'd0;
          rx_d.state    = ST_IDLE;
          if (sync2) strobe_d = 1'b1;
          else       ferr_d   = 1'b1;
        end
      end
      default: rx_d.state = ST_IDLE;
    endcase
  end

  assign rx_byte = shift_q;

endmodule

// File: rtl/m68k_uart_periph.sv
// Memory-mapped 8N1 UART target on the j68 CPU bus.
// Registers on address[3:1]: 0 DATA (W push TX, R pop RX), 1 STATUS, 2 DIV.
// Build option: define M68K_UART_RX_FIFO_EN for a RX_DEPTH-entry RX FIFO;
// otherwise RX storage is a single holding register.
//
// Bus handshake: every access completes and is never stalled. A write is
// acknowledged combinationally (data_ack = sel & wr_ena) and takes effect on
// that clock edge. A read captures rd_data on the sel & rd_ena edge and
// data_ack is asserted during the following cycle.
module m68k_uart_periph
  import m68k_uart_periph_pkg::*;
#(
  parameter int DEFAULT_DIV = 434,
  parameter int RX_DEPTH    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        rd_ena,
  input  logic        wr_ena,
  input  logic [1:0]  byte_ena,
  input  logic [3:0]  address,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        data_ack,
  input  logic        uart_rx,
  output logic        uart_tx
);

  // ---------------------------------------------------------------- bus decode
  logic [2:0]  reg_idx;
  logic        wr_hit, rd_hit;
  logic        data_wr, div_wr, stat_rd, data_rd;
  logic        rd_dly;
  logic [15:0] div_reg;
  logic [15:0] rd_mux;
  logic [15:0] status_word;
  logic        addr_unused;

  // Byte addressing bit 0 has no meaning for 16-bit registers.
  assign addr_unused = address[0];

  assign reg_idx = address[3:1];
  assign wr_hit  = sel & wr_ena;
  assign rd_hit  = sel & rd_ena;
  assign data_wr = wr_hit & (reg_idx == UART_REG_DATA) & byte_ena[0];
  assign div_wr  = wr_hit & (reg_idx == UART_REG_DIV);
  assign stat_rd = rd_hit & (reg_idx == UART_REG_STATUS);
  assign data_rd = rd_hit & (reg_idx == UART_REG_DATA);

  assign data_ack = wr_hit | rd_dly;

  // ------------------------------------------------------------------- signals
  uart_fsm_t  tx_q, tx_d;
  logic [7:0] tx_shift, tx_shift_d;
  logic [7:0] tx_hold;
  logic       tx_full, tx_load, tx_end, tx_line_d;
  logic       tx_accept, tx_ovr_set;
  logic       tx_ovr, rx_ovr, frame_err;

  logic [7:0] rx_byte, rx_head;
  logic       rx_strobe, rx_frame_err;
  logic       rx_valid, rx_pop, rx_ovr_set;

  // A load edge frees the holding register, so a write on that edge is kept.
  assign tx_accept  = data_wr & (~tx_full | tx_load);
  assign tx_ovr_set = data_wr & tx_full & ~tx_load;
  assign rx_pop     = data_rd & rx_valid;

  // Divisor register: byte lanes written independently, result clamped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg <= 16'(DEFAULT_DIV);
    end else if (div_wr) begin
      div_reg <= clamp_div({byte_ena[1] ? wr_data[15:8] : div_reg[15:8],
                            byte_ena[0] ? wr_data[7:0]  : div_reg[7:0]});
    end
  end

  // Read data capture and the one-cycle-late read acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= 16'h0000;
      rd_dly  <= 1'b0;
    end else begin
      rd_dly <= rd_hit;
      if (rd_hit) rd_data <= rd_mux;
    end
  end

  // STATUS word assembly.
  always_comb begin
    status_word                 = 16'h0000;
    status_word[STAT_RX_VALID]  = rx_valid;
    status_word[STAT_TX_FULL]   = tx_full;
    status_word[STAT_TX_BUSY]   = (tx_q.state != ST_IDLE);
    status_word[STAT_RX_OVR]    = rx_ovr;
    status_word[STAT_FRAME_ERR] = frame_err;
    status_word[STAT_TX_OVR]    = tx_ovr;
  end

  // Read multiplexer; unmapped offsets and an empty DATA read return 0.
  always_comb begin
    rd_mux = 16'h0000;
    case (reg_idx)
      UART_REG_DATA:   if (rx_valid) rd_mux = {8'h00, rx_head};
      UART_REG_STATUS: rd_mux = status_word;
      UART_REG_DIV:    rd_mux = div_reg;
      default:         rd_mux = 16'h0000;
    endcase
  end

  // Sticky error flags: a STATUS read clears them unless a new event lands on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ovr    <= 1'b0;
      rx_ovr    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      tx_ovr    <= tx_ovr_set   | (tx_ovr    & ~stat_rd);
      rx_ovr    <= rx_ovr_set   | (rx_ovr    & ~stat_rd);
      frame_err <= rx_frame_err | (frame_err & ~stat_rd);
    end
  end

  // ------------------------------------------------------------------------ TX
  // Holding register: loaded by DATA writes, emptied on a START entry edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_hold <= 8'h00;
      tx_full <= 1'b0;
    end else begin
      if (tx_load) tx_full <= 1'b0;
      if (tx_accept) begin
        tx_hold <= wr_data[7:0];
        tx_full <= 1'b1;
      end
    end
  end

  // TX sequencer state, shifter and registered serial line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q     <= UART_FSM_RESET;
      tx_shift <= 8'h00;
      uart_tx  <= 1'b1;
    end else begin
      tx_q     <= tx_d;
      tx_shift <= tx_shift_d;
      uart_tx  <= tx_line_d;
    end
  end

  assign tx_end = (tx_q.baud_cnt == tx_q.div - 16'd1);

  // TX next state; a new DIV is picked up only when a bit period starts.
  always_comb begin
    tx_d          = tx_q;
    tx_shift_d    = tx_shift;
    tx_load       = 1'b0;
    tx_d.baud_cnt = tx_q.baud_cnt + 16'd1;
    case (tx_q.state)
      ST_IDLE: begin
        tx_d.baud_cnt = 16'd0;
        tx_d.bit_cnt  = 3'd0;
        tx_d.div      = div_reg;
        if (tx_full) begin
          tx_d.state = ST_START;
          tx_load    = 1'b1;
          tx_shift_d = tx_hold;
        end
      end
      ST_START: begin
        if (tx_end) begin
          tx_d.baud_cnt = 16'd0;
          tx_d.div      = div_reg;
          tx_d.bit_cnt  = 3'd0;
          tx_d.state    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_end) begin
          tx_d.baud_cnt = 16'd0;
          tx_d.div      = div_reg;
          if (tx_q.bit_cnt == 3'd7) begin
            tx_d.state = ST_STOP;
          end else begin
            tx_d.bit_cnt = tx_q.bit_cnt + 3'd1;
            tx_shift_d   = {1'b0, tx_shift[7:1]};
          end
        end
      end
      ST_STOP: begin
        if (tx_end) begin
          tx_d.baud_cnt = 16'd0;
          tx_d.div      = div_reg;
          tx_d.bit_cnt  = 3'd0;
          // Back-to-back: a waiting byte starts without an idle bit.
          if (tx_full) begin
            tx_d.state = ST_START;
            tx_load    = 1'b1;
            tx_shift_d = tx_hold;
          end else begin
            tx_d.state = ST_IDLE;
          end
        end
      end
      default: tx_d.state = ST_IDLE;
    endcase
    case (tx_d.state)
      ST_START: tx_line_d = 1'b0;
      ST_DATA:  tx_line_d = tx_shift_d[0];
      default:  tx_line_d = 1'b1;
    endcase
  end

  // ------------------------------------------------------------------------ RX
  m68k_uart_rx u_rx (
    .clk          (clk),
    .rst          (rst),
    .div          (div_reg),
    .uart_rx      (uart_rx),
    .rx_byte      (rx_byte),
    .rx_strobe    (rx_strobe),
    .rx_frame_err (rx_frame_err)
  );

`ifdef M68K_UART_RX_FIFO_EN
  localparam int PTR_W = $clog2(RX_DEPTH);

  logic [7:0]     rx_mem [RX_DEPTH];
  logic [PTR_W:0] rx_wp, rx_rp;
  logic           rx_full, rx_push;

  assign rx_valid   = (rx_wp != rx_rp);
  assign rx_full    = (rx_wp[PTR_W] != rx_rp[PTR_W]) &&
                      (rx_wp[PTR_W-1:0] == rx_rp[PTR_W-1:0]);
  // A pop on the same edge makes room, so a full FIFO can still accept.
  assign rx_push    = rx_strobe & (~rx_full | rx_pop);
  assign rx_ovr_set = rx_strobe & rx_full & ~rx_pop;
  assign rx_head    = rx_mem[rx_rp[PTR_W-1:0]];

  // FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
    end
  end

  // FIFO storage (no reset needed; guarded by the pointers).
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[PTR_W-1:0]] <= rx_byte;
  end
`else
  logic [31:0] rx_depth_unused;
  logic [7:0]  rx_hold;
  logic        rx_hold_valid;

  // Single-entry storage has no use for the FIFO depth.
  assign rx_depth_unused = RX_DEPTH;
  assign rx_valid        = rx_hold_valid;
  assign rx_head         = rx_hold;
  // Any arrival while a byte is held is an overrun and is dropped.
  assign rx_ovr_set      = rx_strobe & rx_hold_valid;

  // Single RX holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_hold       <= 8'h00;
      rx_hold_valid <= 1'b0;
    end else begin
      if (rx_pop) rx_hold_valid <= 1'b0;
      if (rx_strobe && !rx_hold_valid) begin
        rx_hold       <= rx_byte;
        rx_hold_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_m68k_uart_periph.sv
// Directed bench for m68k_uart_periph: register table, TX framing,
// back-to-back TX with overflow, RX receive/frame error/glitch/overrun, reset.
module tb_m68k_uart_periph;
  import m68k_uart_periph_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        rd_ena = 1'b0;
  logic        wr_ena = 1'b0;
  logic [1:0]  byte_ena = 2'b00;
  logic [3:0]  address = 4'h0;
  logic [15:0] wr_data = 16'h0000;
  logic [15:0] rd_data;
  logic        data_ack;
  logic        uart_rx = 1'b1;
  logic        uart_tx;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  m68k_uart_periph dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .rd_ena   (rd_ena),
    .wr_ena   (wr_ena),
    .byte_ena (byte_ena),
    .address  (address),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .data_ack (data_ack),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx)
  );

  // ------------------------------------------------------ clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // --------------------------------------------------------------- scoreboard
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, want);
    end
  endtask

  // ----------------------------------------------------------- driver tasks
  task automatic bus_write(input logic [2:0] rg, input logic [15:0] d, input logic [1:0] be);
    @(negedge clk);
    sel = 1'b1; wr_ena = 1'b1; address = {rg, 1'b0}; wr_data = d; byte_ena = be;
    #1 check("wr_ack", {15'd0, data_ack}, 16'd1);
    @(negedge clk);
    sel = 1'b0; wr_ena = 1'b0; byte_ena = 2'b00;
  endtask

  // Read with ack timing: low in the rd_ena cycle, high the cycle after.
  task automatic bus_read(input logic [2:0] rg, output logic [15:0] d);
    logic early;
    @(negedge clk);
    sel = 1'b1; rd_ena = 1'b1; address = {rg, 1'b0};
    #1 early = data_ack;
    @(negedge clk);
    sel = 1'b0; rd_ena = 1'b0;
    #1 check("rd_ack_timing", {14'd0, early, data_ack}, 16'b01);
    d = rd_data;
  endtask

  task automatic read_expect(input logic [2:0] rg, input logic [15:0] want, input string name);
    logic [15:0] r;
    bus_read(rg, r);
    check(name, r, want);
  endtask

  // Checks a TX frame at DIV=4. immediate=1 means the start bit must already be
  // on the line at entry (back-to-back frame).
  task automatic check_frame(input logic [7:0] b, input bit immediate, input string name);
    logic [9:0] fr;
    logic [3:0] smp;
    int waited;
    fr = {1'b1, b, 1'b0};
    waited = 0;
    if (!immediate) begin
      while (uart_tx !== 1'b0 && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 200) begin
        check({name, "_start_timeout"}, {15'd0, uart_tx}, 16'd0);
        return;
      end
    end
    for (int i = 0; i < 10; i++) begin
      for (int s = 0; s < 4; s++) begin
        smp[s] = uart_tx;
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d", name, i), {12'd0, smp}, fr[i] ? 16'h000F : 16'h0000);
    end
  endtask

  // Serial frame at 4 clocks per bit, then 8 idle clocks.
  task automatic send_serial(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (4) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // ------------------------------------------------------------ vector table
  typedef struct {
    logic        wr;
    logic [2:0]  rg;
    logic [15:0] wd;
    logic [1:0]  be;
    logic [15:0] want;
    string       name;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [15:0] r;

    vecs[0]  = '{wr: 1'b0, rg: UART_REG_STATUS, wd: 16'h0000, be: 2'b00, want: 16'h0000, name: "rst_status"};
    vecs[1]  = '{wr: 1'b0, rg: UART_REG_DIV,    wd: 16'h0000, be: 2'b00, want: 16'h01B2, name: "rst_div"};
    vecs[2]  = '{wr: 1'b0, rg: UART_REG_DATA,   wd: 16'h0000, be: 2'b00, want: 16'h0000, name: "rd_empty_data"};
    vecs[3]  = '{wr: 1'b0, rg: 3'd3,            wd: 16'h0000, be: 2'b00, want: 16'h0000, name: "rd_unmapped3"};
    vecs[4]  = '{wr: 1'b1, rg: UART_REG_DIV,    wd: 16'h0001, be: 2'b11, want: 16'h0000, name: "wr_div1"};
    vecs[5]  = '{wr: 1'b0, rg: UART_REG_DIV,    wd: 16'h0000, be: 2'b00, want: 16'h0002, name: "div_clamp"};
    vecs[6]  = '{wr: 1'b1, rg: UART_REG_DIV,    wd: 16'hAB07, be: 2'b10, want: 16'h0000, name: "wr_div_hi"};
    vecs[7]  = '{wr: 1'b0, rg: UART_REG_DIV,    wd: 16'h0000, be: 2'b00, want: 16'hAB02, name: "div_hi_lane"};
    vecs[8]  = '{wr: 1'b1, rg: UART_REG_DIV,    wd: 16'hFFFF, be: 2'b00, want: 16'h0000, name: "wr_div_nolane"};
    vecs[9]  = '{wr: 1'b0, rg: UART_REG_DIV,    wd: 16'h0000, be: 2'b00, want: 16'hAB02, name: "div_no_lane"};
    vecs[10] = '{wr: 1'b1, rg: 3'd3,            wd: 16'h1234, be: 2'b11, want: 16'h0000, name: "wr_unmapped"};
    vecs[11] = '{wr: 1'b0, rg: 3'd7,            wd: 16'h0000, be: 2'b00, want: 16'h0000, name: "rd_unmapped7"};
    vecs[12] = '{wr: 1'b1, rg: UART_REG_DIV,    wd: 16'h0004, be: 2'b11, want: 16'h0000, name: "wr_div4"};
    vecs[13] = '{wr: 1'b0, rg: UART_REG_DIV,    wd: 16'h0000, be: 2'b00, want: 16'h0004, name: "div_4"};
    vecs[14] = '{wr: 1'b0, rg: UART_REG_STATUS, wd: 16'h0000, be: 2'b00, want: 16'h0000, name: "status_idle"};

    // Reset values of the outputs.
    repeat (3) @(negedge clk);
    check("rst_rd_data", rd_data, 16'h0000);
    check("rst_data_ack", {15'd0, data_ack}, 16'd0);
    check("rst_uart_tx", {15'd0, uart_tx}, 16'd1);
    rst = 1'b0;

    // Register table.
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].rg, vecs[i].wd, vecs[i].be);
      else            read_expect(vecs[i].rg, vecs[i].want, vecs[i].name);
    end

    // Single TX frame 0x55 with STATUS sampled mid-frame (busy, holding empty).
    fork
      begin
        bus_write(UART_REG_DATA, 16'h0055, 2'b01);
        check_frame(8'h55, 1'b0, "tx55");
      end
      begin
        repeat (14) @(negedge clk);
        bus_read(UART_REG_STATUS, r);
        check("status_mid_frame", r, 16'h0004);
      end
    join
    repeat (3) @(negedge clk);
    read_expect(UART_REG_STATUS, 16'h0000, "status_after_tx55");

    // Three back-to-back DATA writes: A1 sent, B2 follows without idle, C3 dropped.
    fork
      begin
        check_frame(8'hA1, 1'b0, "txA1");
        check_frame(8'hB2, 1'b1, "txB2");
      end
      begin
        @(negedge clk);
        sel = 1'b1; wr_ena = 1'b1; address = {UART_REG_DATA, 1'b0}; byte_ena = 2'b01;
        wr_data = 16'h00A1;
        @(negedge clk);
        wr_data = 16'h00B2;
        @(negedge clk);
        wr_data = 16'h00C3;
        @(negedge clk);
        sel = 1'b0; wr_ena = 1'b0; byte_ena = 2'b00;
      end
    join
    repeat (3) @(negedge clk);
    read_expect(UART_REG_STATUS, 16'h0020, "status_tx_ovr");
    read_expect(UART_REG_STATUS, 16'h0000, "status_tx_ovr_cleared");

    // RX byte 0x3C.
    send_serial(8'h3C, 1'b1);
    exp_q.push_back(8'h3C);
    read_expect(UART_REG_STATUS, 16'h0001, "status_rx_valid");
    bus_read(UART_REG_DATA, r);
    check("rx_data_3c", r, {8'h00, exp_q.pop_front()});
    read_expect(UART_REG_STATUS, 16'h0000, "status_rx_empty");

    // Stop bit low: frame error, nothing queued.
    send_serial(8'h5A, 1'b0);
    read_expect(UART_REG_STATUS, 16'h0010, "status_frame_err");
    read_expect(UART_REG_STATUS, 16'h0000, "status_frame_err_cleared");

    // One-clock low glitch must not start a frame.
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (60) @(negedge clk);
    read_expect(UART_REG_STATUS, 16'h0000, "status_after_glitch");
    read_expect(UART_REG_DATA, 16'h0000, "data_after_glitch");

`ifdef M68K_UART_RX_FIFO_EN
    // 17 bytes into a 16-entry FIFO: last one overruns.
    for (int i = 0; i < 17; i++) begin
      send_serial(8'(i), 1'b1);
      if (i < 16) exp_q.push_back(8'(i));
    end
    read_expect(UART_REG_STATUS, 16'h0009, "status_rx_ovr");
    while (exp_q.size() > 0) begin
      bus_read(UART_REG_DATA, r);
      check("rx_fifo_data", r, {8'h00, exp_q.pop_front()});
    end
    read_expect(UART_REG_STATUS, 16'h0000, "status_fifo_drained");
`else
    // Two bytes into the single holding register: first one kept.
    send_serial(8'h11, 1'b1);
    exp_q.push_back(8'h11);
    send_serial(8'h22, 1'b1);
    read_expect(UART_REG_STATUS, 16'h0009, "status_rx_ovr");
    bus_read(UART_REG_DATA, r);
    check("rx_hold_first", r, {8'h00, exp_q.pop_front()});
    read_expect(UART_REG_STATUS, 16'h0000, "status_hold_drained");
`endif

    // Reset in the middle of a TX frame.
    bus_write(UART_REG_DATA, 16'h005A, 2'b01);
    begin
      int waited;
      waited = 0;
      while (uart_tx !== 1'b0 && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      check("rst_tx_frame_started", {15'd0, uart_tx}, 16'd0);
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1 check("rst_tx_async", {15'd0, uart_tx}, 16'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    read_expect(UART_REG_STATUS, 16'h0000, "status_after_rst");
    read_expect(UART_REG_DIV, 16'h01B2, "div_after_rst");
    repeat (50) @(negedge clk);
    check("tx_idle_after_rst", {15'd0, uart_tx}, 16'd1);

    // ------------------------------------------------------------ final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
